// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file completer and its wait-state controller.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

    // One-hot error causes; any set bit makes the transfer answer with PSLVERR
    localparam int unsigned ERR_W = 3;
    localparam logic [ERR_W-1:0] ERR_MISALIGN = 3'b001;
    localparam logic [ERR_W-1:0] ERR_RANGE    = 3'b010;
    localparam logic [ERR_W-1:0] ERR_RO_WRITE = 3'b100;

    localparam int unsigned WORD_LSB = 2;
    localparam int unsigned CNT_W    = 4;

    // Counter preload when leaving SETUP; unused when there are no wait states
    function automatic logic [CNT_W-1:0] wait_init(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? '0 : CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// Transfer sequencer: tracks SETUP/ACCESS, inserts wait states, drives PREADY and the commit strobe.
module apb_wait_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_psel,
    input  logic i_penable,
    output logic o_pready,
    output logic o_setup_c,
    output logic o_enter_done_c,
    output logic o_commit_c
);

    localparam logic [CNT_W-1:0] CNT_INIT = wait_init(WAIT_CYCLES);

    apb_state_e       r_state;
    apb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pready;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        o_setup_c      = 1'b0;
        o_enter_done_c = 1'b0;
        o_commit_c     = 1'b0;
        case (r_state)
            IDLE: begin
                // An ACCESS-phase cycle seen here had no SETUP and is ignored
                if (i_psel && !i_penable) begin
                    o_setup_c = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt    = DONE;
                        o_enter_done_c = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!i_psel) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt    = DONE;
                    o_enter_done_c = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                o_commit_c  = i_psel;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_pready <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pready <= (w_state_nxt == DONE);
        end
    end

    assign o_pready = r_pready;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer serving NREGS-1 read/write control words plus one read-only status word.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 32,
    parameter int unsigned NREGS       = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [AWIDTH-1:0]             PADDR,
    input  logic [DWIDTH-1:0]             PWDATA,
    output logic                          PREADY,
    output logic [DWIDTH-1:0]             PRDATA,
    output logic                          PSLVERR,
    output logic [(NREGS-1)*DWIDTH-1:0]   ctrl_o,
    output logic [NREGS-2:0]              wr_pulse_o,
    input  logic [DWIDTH-1:0]             status_i
);

    localparam int unsigned NRW   = NREGS - 1;
    localparam int unsigned IDX_W = $clog2(NREGS);

    logic                        w_setup_c;
    logic                        w_enter_done_c;
    logic                        w_commit_c;
    logic                        w_commit_wr;
    logic [IDX_W-1:0]            w_dec_idx;
    logic [ERR_W-1:0]            w_cause;
    logic                        w_dec_err;
    logic [IDX_W-1:0]            w_sel_idx;
    logic                        w_sel_err;
    logic                        w_sel_write;
    logic [DWIDTH-1:0]           w_rd_val;
    logic [IDX_W-1:0]            r_idx;
    logic                        r_err;
    logic                        r_write;
    logic [DWIDTH-1:0]           r_wdata;
    logic [DWIDTH-1:0]           r_prdata;
    logic                        r_pslverr;
    logic [NRW-1:0][DWIDTH-1:0]  r_ctrl;
    logic [NRW-1:0]              r_wr_pulse;

    apb_wait_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctrl (
        .i_clk          (PCLK),
        .i_rst_n        (PRESETn),
        .i_psel         (PSEL),
        .i_penable      (PENABLE),
        .o_pready       (PREADY),
        .o_setup_c      (w_setup_c),
        .o_enter_done_c (w_enter_done_c),
        .o_commit_c     (w_commit_c)
    );

    // Address decode of the live bus, used at the SETUP edge
    assign w_dec_idx = PADDR[WORD_LSB +: IDX_W];

    always_comb begin
        w_cause = '0;
        if (PADDR[WORD_LSB-1:0] != '0) begin
            w_cause = w_cause | ERR_MISALIGN;
        end
        if (PADDR >= AWIDTH'(NREGS * 4)) begin
            w_cause = w_cause | ERR_RANGE;
        end
        if (PWRITE && (w_dec_idx == IDX_W'(NREGS - 1))) begin
            w_cause = w_cause | ERR_RO_WRITE;
        end
    end

    assign w_dec_err = |w_cause;

    // With zero wait states DONE is entered on the SETUP edge, before the latch holds the decode
    assign w_sel_idx   = w_setup_c ? w_dec_idx : r_idx;
    assign w_sel_err   = w_setup_c ? w_dec_err : r_err;
    assign w_sel_write = w_setup_c ? PWRITE    : r_write;

    always_comb begin
        w_rd_val = '0;
        if (w_sel_idx == IDX_W'(NREGS - 1)) begin
            w_rd_val = status_i;
        end
        for (int i = 0; i < NRW; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
                w_rd_val = r_ctrl[i];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_setup_c) begin
            r_idx   <= w_dec_idx;
            r_err   <= w_dec_err;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
        end
    end

    // Response is loaded on DONE entry and cleared on every other edge
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_pslverr <= w_enter_done_c && w_sel_err;
            r_prdata  <= (w_enter_done_c && !w_sel_write && !w_sel_err) ? w_rd_val : '0;
        end
    end

    assign w_commit_wr = w_commit_c && r_write && !r_err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_ctrl     <= '0;
            r_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NRW; i++) begin
                r_wr_pulse[i] <= w_commit_wr && (r_idx == IDX_W'(i));
                if (w_commit_wr && (r_idx == IDX_W'(i))) begin
                    r_ctrl[i] <= r_wdata;
                end
            end
        end
    end

    assign PRDATA     = r_prdata;
    assign PSLVERR    = r_pslverr;
    assign ctrl_o     = r_ctrl;
    assign wr_pulse_o = r_wr_pulse;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized self-checking bench: three completers (0, 2 and 3 wait states) against a transaction-level model.
`timescale 1ns/1ps
module tb_apb_slave_regfile;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned NR  = 8;
    localparam int unsigned NRW = NR - 1;
    localparam int          ND  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [DW-1:0] status;
    logic psel [ND];
    logic penable [ND];
    logic pwrite [ND];
    logic [AW-1:0] paddr [ND];
    logic [DW-1:0] pwdata [ND];
    logic pready [ND];
    logic [DW-1:0] prdata [ND];
    logic pslverr [ND];
    logic [NRW*DW-1:0] ctrl [ND];
    logic [NRW-1:0] pulse [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        apb_slave_regfile #(
            .DWIDTH      (DW),
            .AWIDTH      (AW),
            .NREGS       (NR),
            .WAIT_CYCLES ((g == 0) ? 0 : g + 1)
        ) u_dut (
            .PCLK       (clk),
            .PRESETn    (rst_n),
            .PSEL       (psel[g]),
            .PENABLE    (penable[g]),
            .PWRITE     (pwrite[g]),
            .PADDR      (paddr[g]),
            .PWDATA     (pwdata[g]),
            .PREADY     (pready[g]),
            .PRDATA     (prdata[g]),
            .PSLVERR    (pslverr[g]),
            .ctrl_o     (ctrl[g]),
            .wr_pulse_o (pulse[g]),
            .status_i   (status)
        );
    end

    // Reference state: register contents, pending pulse, and per-cycle expectations
    logic [DW-1:0]     m_reg [ND][NRW];
    logic [NRW-1:0]    pend [ND];
    bit                e_rdy [ND];
    logic [DW-1:0]     e_rd [ND];
    bit                e_err [ND];
    logic [NRW*DW-1:0] e_ctrl [ND];
    logic [NRW-1:0]    e_pulse [ND];

    bit            b_wr;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic [DW-1:0] b_sts;
    bit            chk = 1'b0;
    int            n_vec = 0;
    int            n_miss = 0;

    function automatic int wc(input int d);
        return (d == 0) ? 0 : d + 1;
    endfunction

    task automatic cmp(input string nm, input int d, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < ND; d++) begin
            for (int r = 0; r < NRW; r++) m_reg[d][r] = '0;
            pend[d]    = '0;
            e_rdy[d]   = 1'b0;
            e_rd[d]    = '0;
            e_err[d]   = 1'b0;
            e_ctrl[d]  = '0;
            e_pulse[d] = '0;
        end
    endtask

    // One bus cycle: drive inputs to DUT d (others idle) and state what the outputs must show now
    task automatic cyc(input int d, input logic sel, input logic en, input bit rdy,
                       input logic [DW-1:0] rd, input bit err);
        @(posedge clk);
        #1;
        status = b_sts;
        for (int e = 0; e < ND; e++) begin
            psel[e]    = (e == d) ? sel : 1'b0;
            penable[e] = (e == d) ? en : 1'b0;
            pwrite[e]  = b_wr;
            paddr[e]   = b_addr;
            pwdata[e]  = b_wdata;
            e_rdy[e]   = (e == d) && rdy;
            e_rd[e]    = (e == d) ? rd : '0;
            e_err[e]   = (e == d) && err;
            e_pulse[e] = pend[e];
            pend[e]    = '0;
            for (int r = 0; r < NRW; r++) e_ctrl[e][r*DW +: DW] = m_reg[e][r];
        end
    endtask

    // Whole APB transfer on DUT d; abort_k > 0 drops PSEL in that ACCESS cycle
    task automatic xfer(input int d, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] sts, input int abort_k,
                        output int lat, output logic [DW-1:0] rd_seen, output logic err_seen);
        int unsigned idx;
        bit err;
        logic [DW-1:0] rv;
        int n;
        idx = int'(addr >> 2);
        err = (addr[1:0] != 2'b00) || (addr >= AW'(NR * 4)) || (wr && idx == NR - 1);
        rv = '0;
        if (!wr && !err) rv = (idx == NR - 1) ? sts : m_reg[d][idx];
        n = wc(d) + 1;
        b_wr = wr; b_addr = addr; b_wdata = wd; b_sts = sts;
        cyc(d, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        lat = 0; rd_seen = '0; err_seen = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (k == n) b_sts = ~sts;
            cyc(d, (k != abort_k), (k != abort_k), (k == n), (k == n) ? rv : '0, (k == n) && err);
            #1;
            if (pready[d] !== 1'b1) lat++;
            else begin
                rd_seen  = prdata[d];
                err_seen = pslverr[d];
            end
            if (k == abort_k) return;
        end
        if (wr && !err) begin
            m_reg[d][idx] = wd;
            pend[d] = NRW'(1) << idx;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) cyc(int'($urandom_range(0, ND - 1)), 1'b1, 1'b1, 1'b0, '0, 1'b0);
            else cyc(-1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int d = 0; d < ND; d++) begin
            cmp({nm, "_PREADY"}, d, 256'(pready[d]), '0);
            cmp({nm, "_PRDATA"}, d, 256'(prdata[d]), '0);
            cmp({nm, "_PSLVERR"}, d, 256'(pslverr[d]), '0);
            cmp({nm, "_ctrl"}, d, 256'(ctrl[d]), '0);
            cmp({nm, "_pulse"}, d, 256'(pulse[d]), '0);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            for (int d = 0; d < ND; d++) begin
                cmp("PREADY", d, 256'(pready[d]), 256'(e_rdy[d]));
                cmp("PRDATA", d, 256'(prdata[d]), 256'(e_rd[d]));
                cmp("PSLVERR", d, 256'(pslverr[d]), 256'(e_err[d]));
                cmp("ctrl_o", d, 256'(ctrl[d]), 256'(e_ctrl[d]));
                cmp("wr_pulse_o", d, 256'(pulse[d]), 256'(e_pulse[d]));
            end
        end
    end

    initial begin
        int lat;
        logic [DW-1:0] rd;
        logic er;
        int d;
        bit wr;
        logic [AW-1:0] a;
        int ab;

        rst_n = 1'b0;
        b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_sts = '0; status = '0;
        for (int e = 0; e < ND; e++) begin
            psel[e] = 1'b0; penable[e] = 1'b0; pwrite[e] = 1'b0; paddr[e] = '0; pwdata[e] = '0;
        end
        clear_model();
        chk = 1'b1;
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk_zero("reset");
        rst_n = 1'b1;
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Zero-wait write then read back
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, '0, 0, lat, rd, er);
        cmp("zw_wr_latency", 0, 256'(lat), 256'(0));
        cmp("zw_wr_err", 0, 256'(er), 256'(0));
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cmp("zw_pulse", 0, 256'(pulse[0]), 256'(7'b0000010));
        cmp("zw_reg1", 0, 256'(ctrl[0][63:32]), 256'(32'hDEADBEEF));
        xfer(0, 1'b0, 32'h04, '0, 32'h5555_5555, 0, lat, rd, er);
        cmp("zw_rd_data", 0, 256'(rd), 256'(32'hDEADBEEF));
        cmp("zw_rd_err", 0, 256'(er), 256'(0));

        // Three wait states
        xfer(2, 1'b0, 32'h00, '0, 32'hA5A5_A5A5, 0, lat, rd, er);
        cmp("ws3_latency", 2, 256'(lat), 256'(3));
        cmp("ws3_rd_data", 2, 256'(rd), 256'(0));

        // Error cases and the read-only status word
        xfer(0, 1'b1, 32'h02, 32'h1111_1111, '0, 0, lat, rd, er);
        cmp("err_misalign", 0, 256'(er), 256'(1));
        xfer(0, 1'b1, 32'h40, 32'h2222_2222, '0, 0, lat, rd, er);
        cmp("err_range", 0, 256'(er), 256'(1));
        xfer(0, 1'b1, 32'h1C, 32'h3333_3333, '0, 0, lat, rd, er);
        cmp("err_ro_write", 0, 256'(er), 256'(1));
        xfer(0, 1'b0, 32'h1C, '0, 32'h0000_1234, 0, lat, rd, er);
        cmp("status_rd_data", 0, 256'(rd), 256'(32'h1234));
        cmp("status_rd_err", 0, 256'(er), 256'(0));

        // Back-to-back writes
        xfer(0, 1'b1, 32'h00, 32'h0101_0101, '0, 0, lat, rd, er);
        xfer(0, 1'b1, 32'h08, 32'h0808_0808, '0, 0, lat, rd, er);
        xfer(0, 1'b1, 32'h0C, 32'h0C0C_0C0C, '0, 0, lat, rd, er);
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cmp("b2b_pulse", 0, 256'(pulse[0]), 256'(7'b0001000));
        cmp("b2b_reg2", 0, 256'(ctrl[0][95:64]), 256'(32'h0808_0808));

        // Aborts: in WAIT (2 wait states) and in DONE (zero wait)
        xfer(1, 1'b1, 32'h10, 32'hCAFE_0000, '0, 1, lat, rd, er);
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cmp("abort_pulse", 1, 256'(pulse[1]), '0);
        cmp("abort_reg4", 1, 256'(ctrl[1][159:128]), '0);
        xfer(0, 1'b1, 32'h14, 32'hBEEF_0005, '0, 1, lat, rd, er);
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cmp("abort_done_reg5", 0, 256'(ctrl[0][191:160]), '0);

        // Reset asserted while DUT 2 is waiting
        b_wr = 1'b1; b_addr = 32'h08; b_wdata = 32'h0BAD_F00D;
        cyc(2, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(2, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk_zero("async_rst");
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;
        cyc(-1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        xfer(2, 1'b1, 32'h08, 32'h0BAD_F00D, '0, 0, lat, rd, er);
        xfer(2, 1'b0, 32'h08, '0, '0, 0, lat, rd, er);
        cmp("post_rst_rd", 2, 256'(rd), 256'(32'h0BAD_F00D));

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            d  = int'($urandom_range(0, ND - 1));
            wr = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0: a = AW'(($urandom_range(0, NR - 1) << 2) | $urandom_range(1, 3));
                1: a = AW'($urandom);
                2: a = AW'(NR * 4) + AW'($urandom_range(0, 15) << 2);
                default: a = AW'($urandom_range(0, NR - 1) << 2);
            endcase
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, wc(d) + 1)) : 0;
            xfer(d, wr, a, DW'($urandom), DW'($urandom), ab, lat, rd, er);
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

Clocked APB3 completer that terminates transfers from the APB master (PSEL/PENABLE initiator) and serves a small word-addressed register bank. It decodes the address, inserts a programmable number of wait states, and flags bad accesses with PSLVERR. Control registers drive fabric logic downstream; one read-only status word is sampled from the fabric.

## Interface
- DWIDTH, 32, data width in bits (PRDATA, PWDATA, registers)
- AWIDTH, 32, address width in bits
- NREGS, 8, number of word registers (≥2); indices 0..NREGS-2 RW, index NREGS-1 RO status
- WAIT_CYCLES, 1, ACCESS cycles with PREADY low before completion (0..15)

Ports:
- PCLK  in  1  single clock, all state on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  completer select
- PENABLE  in  1  ACCESS phase marker
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  AWIDTH  byte address
- PWDATA  in  DWIDTH  write data
- PREADY  out  1  transfer completes in this cycle (registered)
- PRDATA  out  DWIDTH  read data, valid while PREADY=1 on reads (registered)
- PSLVERR  out  1  error, valid only while PREADY=1 (registered)
- ctrl_o  out  (NREGS-1)*DWIDTH  flattened RW register contents, reg i at [i*DWIDTH +: DWIDTH]
- wr_pulse_o  out  NREGS-1  one-cycle pulse per RW register on committed write
- status_i  in  DWIDTH  RO status word, sampled on read

## Operation
- Reset (PRESETn=0, async): state IDLE, PREADY=0, PRDATA=0, PSLVERR=0, all ctrl registers 0, wr_pulse_o=0, wait counter 0.
- States IDLE, WAIT, DONE.
- IDLE: on edge with PSEL=1, PENABLE=0 (SETUP) latch PADDR, PWRITE, PWDATA and decode; go DONE if WAIT_CYCLES=0, else WAIT with cnt=WAIT_CYCLES-1. PENABLE=1 without prior SETUP ignored.
- WAIT: PREADY=0; if cnt=0 go DONE, else cnt decrements.
- Entering DONE: PREADY←1; PSLVERR←err; PRDATA←read value for error-free reads, else 0.
- DONE: the edge leaving DONE is the completion edge; commit write if PWRITE & !err: ctrl[idx]←latched PWDATA, wr_pulse_o[idx]=1 for the following cycle. Always return to IDLE; PREADY, PSLVERR, PRDATA clear to 0.
- Error conditions (any sets err): PADDR[1:0]≠0; PADDR ≥ NREGS*4; write to index NREGS-1. Errored writes change no register and fire no pulse.
- Read value: ctrl[idx] for idx<NREGS-1; status_i sampled at DONE entry for idx=NREGS-1.
- Abort: PSEL=0 while in WAIT or DONE → IDLE next edge, no commit, outputs cleared.
- Reset asserted mid-transfer: immediate return to reset values, no partial write.

## Timing
- Transfer length = 2 + WAIT_CYCLES cycles (SETUP + ACCESS cycles); WAIT_CYCLES=0 gives zero-wait APB.
- Back-to-back: next SETUP may occupy the cycle after completion; no idle cycle required.
- Write data visible on ctrl_o the cycle after the completion edge, coincident with wr_pulse_o.
- status_i sampled at the edge ending the last PREADY=0 cycle (or the SETUP edge for WAIT_CYCLES=0).
- No combinational path from any input to PREADY, PRDATA, PSLVERR.

## Structure
- Package apb_pkg: state enum (IDLE/WAIT/DONE), error-cause constants (MISALIGN, RANGE, RO_WRITE), word-address LSB constant (2).
- Sub-module apb_wait_ctrl: FSM plus wait counter, outputs PREADY and a commit strobe; top holds decode and register bank.

## Test plan
- Zero-wait write then read (WAIT_CYCLES=0): write 0xDEADBEEF to 0x04 → PREADY=1 in first ACCESS cycle, ctrl reg1=0xDEADBEEF, wr_pulse_o=0b0000010 one cycle; read 0x04 returns 0xDEADBEEF, PSLVERR=0.
- Wait states (WAIT_CYCLES=3): read of 0x00 → exactly 3 ACCESS cycles PREADY=0, then 1 cycle PREADY=1, total 5 cycles.
- Errors: write 0x02, write 0x40 (NREGS=8), write 0x1C → each PSLVERR=1 with PREADY, no register change, no pulse; read 0x1C with status_i=0x1234 → PRDATA=0x1234, PSLVERR=0.
- Back-to-back: three writes with no idle cycles to 0x00/0x08/0x0C → all committed, pulses on consecutive-transfer boundaries.
- Abort: WAIT_CYCLES=2, drop PSEL in first ACCESS cycle of write → state IDLE, register unchanged, no pulse.
- Reset mid-transfer: assert PRESETn=0 during WAIT → all outputs and registers 0 asynchronously; next transfer after release completes normally.
